usb_rx_ctrl: RTL and testbench
==============================

// Module: usb_rx_ctrl
// PURPOSE
//  Receive control unit for the USB full-speed receiver. Sequences the NRZI decode / shift datapath:
//  detects packet start, checks the SYNC byte, strobes each received byte into the RX FIFO, and
//  validates EOP placement. Flags framing/overflow errors.
//  Sits between edge/EOP detectors + 8-bit shift register and the RX FIFO write port.
// PARAMETERS
//  SYNC_BYTE  8'h80  required first byte (post-decode, LSB-first shift register image)
//  MAX_BYTES  64     max data bytes per packet after SYNC; the (MAX_BYTES+1)th byte is an error
// PORTS
//  clk            in   1  system clock
//  rst            in   1  asynchronous, active-high reset
//  d_edge         in   1  1-cycle pulse: transition seen on d_plus
//  eop            in   1  level: SE0 currently present on bus
//  shift_enable   in   1  1-cycle bit-sample strobe from timer
//  byte_received  in   1  1-cycle pulse: 8 bits collected in shift register
//  rcv_data       in   8  shift register contents, valid when byte_received=1
//  timer_clr      out  1  1-cycle pulse: resynchronise bit timer at packet start
//  rcving         out  1  high from packet start until EOP/idle recovery done
//  w_enable       out  1  1-cycle FIFO write strobe for rcv_data
//  r_error        out  1  sticky packet error; cleared on next packet start
//  byte_count     out  7  data bytes written in current packet (SYNC not counted)
// BEHAVIOUR
//  Reset: state IDLE; timer_clr=0 rcving=0 w_enable=0 r_error=0 byte_count=0. Reset mid-packet
//   aborts immediately; no FIFO write is issued on the reset edge or after it.
//  All outputs registered or decoded from state; one-cycle decision latency per event.
//  States/transitions (only these, evaluated each rising clk):
//   IDLE     : d_edge -> SYNC_RX; that cycle: timer_clr=1 next cycle, r_error<=0, byte_count<=0
//   SYNC_RX  : byte_received -> SYNC_CHK; eop&shift_enable -> ERR_EOP (r_error<=1)
//   SYNC_CHK : rcv_data==SYNC_BYTE -> BYTE_RX, else -> ERR_WAIT (r_error<=1)
//   BYTE_RX  : byte_received -> STORE; eop&shift_enable -> ERR_EOP (r_error<=1, partial byte)
//   STORE    : w_enable=1 exactly 1 cycle; byte_count<=byte_count+1; -> EOP_CHK
//              if byte_count==MAX_BYTES on entry: no w_enable, r_error<=1, -> ERR_WAIT
//   EOP_CHK  : next shift_enable: eop=1 -> EOP_END; eop=0 -> BYTE_RX
//   EOP_END  : d_edge (bus returns to J) -> IDLE; rcving<=0
//   ERR_WAIT : eop&shift_enable -> ERR_EOP
//   ERR_EOP  : d_edge -> IDLE; rcving<=0; r_error stays 1
//  rcving=1 in every state except IDLE. r_error holds through IDLE until next d_edge in IDLE.
//  Simultaneous byte_received & eop&shift_enable in BYTE_RX: byte_received wins (-> STORE).
//  d_edge outside IDLE/EOP_END/ERR_EOP ignored. byte_count saturates at MAX_BYTES (never wraps).
//  Zero-data packet (SYNC then EOP): SYNC_CHK -> BYTE_RX -> eop&shift_enable -> ERR_EOP is NOT
//   used; SYNC_CHK ok -> EOP_CHK path taken instead so SYNC+EOP is legal, r_error=0, count=0.
//   (i.e. SYNC_CHK success goes to EOP_CHK, not BYTE_RX.)
// STRUCTURE
//  Package usb_rx_pkg: state_t enum (IDLE,SYNC_RX,SYNC_CHK,BYTE_RX,STORE,EOP_CHK,EOP_END,
//   ERR_WAIT,ERR_EOP), SYNC_PID_DEFAULT=8'h80, BYTE_CNT_W=7.
//  One sub-module: usb_rx_byte_cnt (sync clear, enable, saturating at MAX_BYTES, async rst).
//  Top: state register + next-state/output case block; no other hierarchy.
// TESTING
//  1 Assert rst mid-BYTE_RX -> all outputs 0 same cycle; next d_edge restarts cleanly.
//  2 d_edge, SYNC 8'h80, bytes 8'hA5,8'h3C, EOP at shift_enable -> two w_enable pulses
//    (rcv_data A5 then 3C), byte_count=2, r_error=0, rcving drops after closing d_edge.
//  3 d_edge, first byte 8'h81 -> r_error=1, no w_enable; after EOP+d_edge IDLE with r_error=1;
//    next d_edge clears r_error.
//  4 SYNC, 3 bits of data then eop&shift_enable -> r_error=1, no w_enable, -> ERR_EOP.
//  5 SYNC + MAX_BYTES+1 bytes -> exactly 64 w_enable pulses, byte_count=64, r_error=1.
//  6 SYNC then immediate EOP -> r_error=0, byte_count=0, rcving falls on closing d_edge.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared state encoding and constants
// for the USB full-speed receive controller.
package usb_rx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SYNC_RX,
    SYNC_CHK,
    BYTE_RX,
    STORE,
    EOP_CHK,
    EOP_END,
    ERR_WAIT,
    ERR_EOP
  } state_t;

  localparam logic [7:0] SYNC_PID_DEFAULT = 8'h80;
  localparam int BYTE_CNT_W = 7;

endpackage

// File: rtl/usb_rx_byte_cnt.sv
// usb_rx_byte_cnt: saturating data-byte counter.
// Ports: clk, rst (async high), clr (sync), en, count, full (count==MAX).
import usb_rx_pkg::*;

module usb_rx_byte_cnt #(
  parameter int MAX = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [BYTE_CNT_W-1:0] count,
  output logic                  full
);

  localparam logic [BYTE_CNT_W-1:0] MAX_C = BYTE_CNT_W'(MAX);

  assign full = (count == MAX_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !full) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: USB FS receive sequencer (SYNC check, byte strobe, EOP check).
// In: d_edge eop shift_enable byte_received rcv_data; out: timer_clr rcving w_enable r_error byte_count.
import usb_rx_pkg::*;

module usb_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE = SYNC_PID_DEFAULT,
  parameter int         MAX_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_edge,
  input  logic                  eop,
  input  logic                  shift_enable,
  input  logic                  byte_received,
  input  logic [7:0]            rcv_data,
  output logic                  timer_clr,
  output logic                  rcving,
  output logic                  w_enable,
  output logic                  r_error,
  output logic [BYTE_CNT_W-1:0] byte_count
);

  state_t state;
  logic   cnt_full;
  logic   eop_se;
  logic   start;

  assign eop_se = eop & shift_enable;
  assign start  = (state == IDLE) & d_edge;

  usb_rx_byte_cnt #(
    .MAX (MAX_BYTES)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .en    (state == STORE),
    .count (byte_count),
    .full  (cnt_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer_clr <= 1'b0;
      rcving    <= 1'b0;
      w_enable  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      timer_clr <= 1'b0;
      w_enable  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_edge) begin
            state     <= SYNC_RX;
            timer_clr <= 1'b1;
            rcving    <= 1'b1;
            r_error   <= 1'b0;
          end
        end
        SYNC_RX: begin
          if (byte_received) begin
            state <= SYNC_CHK;
          end else if (eop_se) begin
            state   <= ERR_EOP;
            r_error <= 1'b1;
          end
        end
        SYNC_CHK: begin
          // Good SYNC goes to EOP_CHK so a SYNC+EOP packet is legal.
          if (rcv_data == SYNC_BYTE) begin
            state <= EOP_CHK;
          end else begin
            state   <= ERR_WAIT;
            r_error <= 1'b1;
          end
        end
        BYTE_RX: begin
          if (byte_received) begin
            state    <= STORE;
            // Write strobe is high for the whole STORE cycle,
            // suppressed when this byte would overflow.
            w_enable <= !cnt_full;
          end else if (eop_se) begin
            state   <= ERR_EOP;
            r_error <= 1'b1;
          end
        end
        STORE: begin
          if (cnt_full) begin
            state   <= ERR_WAIT;
            r_error <= 1'b1;
          end else begin
            state <= EOP_CHK;
          end
        end
        EOP_CHK: begin
          if (shift_enable) begin
            state <= eop ? EOP_END : BYTE_RX;
          end
        end
        EOP_END, ERR_EOP: begin
          if (d_edge) begin
            state  <= IDLE;
            rcving <= 1'b0;
          end
        end
        ERR_WAIT: begin
          if (eop_se) begin
            state <= ERR_EOP;
          end
        end
        default: begin
          state  <= IDLE;
          rcving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: directed scoreboard bench for usb_rx_ctrl.
// Expected FIFO bytes are queued at stimulus time and popped on w_enable.
module tb_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_edge = 1'b0;
  logic       eop = 1'b0;
  logic       shift_enable = 1'b0;
  logic       byte_received = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       timer_clr;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic [6:0] byte_count;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_wr = 0;
  int         wr_mark;
  logic [7:0] exp_q[$];

  usb_rx_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .d_edge        (d_edge),
    .eop           (eop),
    .shift_enable  (shift_enable),
    .byte_received (byte_received),
    .rcv_data      (rcv_data),
    .timer_clr     (timer_clr),
    .rcving        (rcving),
    .w_enable      (w_enable),
    .r_error       (r_error),
    .byte_count    (byte_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_enable === 1'b1) begin
      n_wr++;
      n_vec++;
      if (exp_q.size() == 0) begin
        assert (0) else begin
          n_err++;
          $error("FAIL wr_unexpected obs=%h exp=none", rcv_data);
        end
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        assert (rcv_data === e) else begin
          n_err++;
          $error("FAIL wr_data obs=%h exp=%h", rcv_data, e);
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    d_edge        = 1'b0;
    shift_enable  = 1'b0;
    byte_received = 1'b0;
  endtask

  task automatic edge_pulse();
    d_edge = 1'b1;
    tick();
  endtask

  task automatic send_sync(input logic [7:0] b);
    shift_enable = 1'b1;
    tick();
    rcv_data      = b;
    byte_received = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stored);
    shift_enable = 1'b1;
    tick();
    tick();
    rcv_data      = b;
    byte_received = 1'b1;
    if (stored) exp_q.push_back(b);
    tick();
    tick();
    tick();
  endtask

  task automatic eop_then_idle();
    eop          = 1'b1;
    shift_enable = 1'b1;
    tick();
    tick();
    eop = 1'b0;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_timer_clr", 32'(timer_clr), 0);
    chk("rst_rcving", 32'(rcving), 0);
    chk("rst_w_enable", 32'(w_enable), 0);
    chk("rst_r_error", 32'(r_error), 0);
    chk("rst_count", 32'(byte_count), 0);
    tick();
    rst = 1'b0;
    tick();

    // test 1: reset mid BYTE_RX
    edge_pulse();
    chk("t1_timer_clr", 32'(timer_clr), 1);
    chk("t1_rcving", 32'(rcving), 1);
    send_sync(8'h80);
    send_byte(8'h11, 1'b1);
    chk("t1_count1", 32'(byte_count), 1);
    shift_enable = 1'b1;
    tick();
    rcv_data      = 8'h22;
    byte_received = 1'b1;
    rst           = 1'b1;
    #1;
    chk("t1_rcving0", 32'(rcving), 0);
    chk("t1_count0", 32'(byte_count), 0);
    chk("t1_err0", 32'(r_error), 0);
    chk("t1_wen0", 32'(w_enable), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t1_idle", 32'(rcving), 0);

    // test 2: normal two-byte packet
    wr_mark = n_wr;
    edge_pulse();
    chk("t2_timer_clr", 32'(timer_clr), 1);
    tick();
    chk("t2_timer_clr_pulse", 32'(timer_clr), 0);
    send_sync(8'h80);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    eop_then_idle();
    chk("t2_count", 32'(byte_count), 2);
    chk("t2_err", 32'(r_error), 0);
    chk("t2_rcving_hold", 32'(rcving), 1);
    chk("t2_writes", 32'(n_wr - wr_mark), 2);
    edge_pulse();
    chk("t2_rcving_drop", 32'(rcving), 0);

    // test 3: bad SYNC byte
    wr_mark = n_wr;
    edge_pulse();
    send_sync(8'h81);
    chk("t3_err", 32'(r_error), 1);
    eop_then_idle();
    edge_pulse();
    chk("t3_idle", 32'(rcving), 0);
    chk("t3_err_hold", 32'(r_error), 1);
    chk("t3_no_write", 32'(n_wr - wr_mark), 0);
    edge_pulse();
    chk("t3_err_clr", 32'(r_error), 0);

    // test 4: EOP mid-byte (continues packet started above)
    wr_mark = n_wr;
    send_sync(8'h80);
    for (int i = 0; i < 4; i++) begin
      shift_enable = 1'b1;
      tick();
    end
    chk("t4_err_pre", 32'(r_error), 0);
    eop          = 1'b1;
    shift_enable = 1'b1;
    tick();
    chk("t4_err", 32'(r_error), 1);
    eop = 1'b0;
    tick();
    chk("t4_rcving", 32'(rcving), 1);
    edge_pulse();
    chk("t4_idle", 32'(rcving), 0);
    chk("t4_no_write", 32'(n_wr - wr_mark), 0);

    // test 5: overflow at MAX_BYTES+1
    wr_mark = n_wr;
    edge_pulse();
    send_sync(8'h80);
    for (int i = 0; i < 64; i++) begin
      send_byte(8'(i * 7 + 3), 1'b1);
    end
    chk("t5_err_pre", 32'(r_error), 0);
    send_byte(8'hEE, 1'b0);
    chk("t5_count", 32'(byte_count), 64);
    chk("t5_err", 32'(r_error), 1);
    chk("t5_writes", 32'(n_wr - wr_mark), 64);
    eop_then_idle();
    edge_pulse();
    chk("t5_idle", 32'(rcving), 0);
    chk("t5_count_sat", 32'(byte_count), 64);

    // test 6: SYNC then immediate EOP
    edge_pulse();
    send_sync(8'h80);
    eop_then_idle();
    chk("t6_err", 32'(r_error), 0);
    chk("t6_count", 32'(byte_count), 0);
    chk("t6_rcving", 32'(rcving), 1);
    edge_pulse();
    chk("t6_rcving_drop", 32'(rcving), 0);

    // test 7: byte_received beats eop&shift_enable
    wr_mark = n_wr;
    edge_pulse();
    send_sync(8'h80);
    shift_enable = 1'b1;
    tick();
    tick();
    rcv_data      = 8'h5A;
    byte_received = 1'b1;
    eop           = 1'b1;
    shift_enable  = 1'b1;
    exp_q.push_back(8'h5A);
    tick();
    tick();
    shift_enable = 1'b1;
    tick();
    eop = 1'b0;
    chk("t7_writes", 32'(n_wr - wr_mark), 1);
    chk("t7_err", 32'(r_error), 0);
    chk("t7_count", 32'(byte_count), 1);
    edge_pulse();
    chk("t7_idle", 32'(rcving), 0);

    tick();
    chk("q_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
